ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the execute stage and the memory stage of the RV32I core. It captures the ALU result and the control fields, and resolves conditional branches from the ALU flags `EQ`, `C` and `S`. It also resolves JAL/JALR targets. When a transfer is taken, it issues a one-cycle PC redirect and squashes the wrong-path instruction that follows. It supports pipeline stall (hold) and external flush.

## Interface
- `WIDTH`, 32, datapath width
- `REGW`, 5, register index width
- `clk` input 1: clock; all state updates on the rising edge
- `rst` input 1: reset, asynchronous and active-high
- `ex_valid` input 1: the EX slot holds a real instruction
- `ex_alu_out` input WIDTH: ALU result
- `ex_eq`, `ex_c`, `ex_s` input 1 each: ALU flags
  - `ex_eq`: op1==op2
  - `ex_c`: op1<op2 unsigned
  - `ex_s`: op1<op2 signed
- `ex_pc` input WIDTH: PC of the EX instruction
- `ex_imm` input WIDTH: sign-extended immediate
- `ex_rs2_data` input WIDTH: store data
- `ex_rd` input REGW: destination register
- `ex_funct3` input 3: funct3 field
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` input 1 each: control bits
- `ex_branch`, `ex_jal`, `ex_jalr` input 1 each: transfer type, mutually exclusive
- `stall` input 1: hold all stage contents
- `flush` input 1: kill the entry being captured
- `m_valid` output 1: MEM slot valid
- `m_alu_out`, `m_rs2_data`, `m_pc_plus4` output WIDTH: registered datapath values
- `m_rd` output REGW: registered destination register
- `m_funct3` output 3: registered funct3
- `m_reg_write`, `m_mem_read`, `m_mem_write` output 1 each: registered control bits, gated by `m_valid`
- `redirect` output 1: one-cycle request to load `redirect_pc`
- `redirect_pc` output WIDTH: target PC
- `misaligned` output 1: the taken target is not 4-byte aligned

## Operation
- Branch condition by `ex_funct3`:
  - 000: taken when `eq`
  - 001: taken when `!eq`
  - 100: taken when `s`
  - 101: taken when `!s`
  - 110: taken when `c`
  - 111: taken when `!c`
  - 010, 011: never taken
- take = `ex_valid & (ex_jal | ex_jalr | (ex_branch & cond))`.
- Target:
  - Branch or JAL: `ex_pc + ex_imm`, mod 2^WIDTH (wraps).
  - JALR: `ex_alu_out & ~1`.
- `m_pc_plus4` = `ex_pc + 4`, wraps, no overflow flag.
- Registered state: all `m_*` fields, `take_q`, `target_q`, `issued_q`, `squash_q`.
- `redirect` = `m_valid & take_q & ~issued_q & ~misaligned`; `redirect_pc` = `target_q`.
- `misaligned` = `m_valid & take_q & (target_q[1:0] != 0)`. A misaligned target never redirects; the trap logic consumes the flag.
- Per-edge priority, highest first:
  1. `rst`
  2. `flush`: `m_valid` <- 0, `squash_q` <- 0, `issued_q` <- 0
  3. `stall`: hold all fields; `issued_q` <- `issued_q | redirect`; `squash_q` <- `squash_q | redirect`
  4. Capture: load EX fields; `m_valid` <- `ex_valid & ~(redirect | squash_q)`; `issued_q` <- 0; `squash_q` <- 0
- A squashed capture loads data but clears `m_valid`. All gated controls go low and `take_q` is ignored.
- State is a two-bit redirect FSM per occupied slot:
  - IDLE -> (valid & take) ISSUE
  - ISSUE -> (stall) DONE
  - ISSUE -> (no stall) next capture
  - DONE holds until the next capture or a flush.

## Timing
- Reset values:
  - `m_valid`=0; all `m_*` data fields, `target_q`, `redirect_pc` = 0; `take_q`, `issued_q`, `squash_q` = 0.
  - Hence `redirect`=0 and `misaligned`=0.
- Latency: 1 cycle, EX inputs to `m_*` outputs.
- `redirect` and `redirect_pc` are valid in the cycle after capture and depend only on registered state (no input-to-output path).
- `redirect` is high for exactly one cycle per taken instruction, including when stalled for N cycles.
- Exactly one wrong-path EX instruction is squashed per redirect. If the redirect cycle is stalled, the squash applies to the first non-stalled capture.
- Reset asserted mid-operation clears all state immediately, asynchronously.
- Simultaneous `flush` and `stall`: flush wins.

## Test plan
- BEQ
  - Stimulus: `ex_eq`=1, pc=0x100, imm=0x20.
  - Response: next cycle `redirect`=1, `redirect_pc`=0x120; following cycle `redirect`=0. The EX instruction presented in the redirect cycle yields `m_valid`=0.
- BLTU not taken
  - Stimulus: `ex_c`=0, funct3=110.
  - Response: `redirect` stays 0 and the next instruction is captured valid.
  - Repeat with funct3=010: never taken.
- JALR
  - Stimulus: `ex_alu_out`=0x2003.
  - Response: `redirect_pc`=0x2002 and `misaligned`=1 with `redirect`=0.
  - Stimulus: `ex_alu_out`=0x2001.
  - Response: `redirect_pc`=0x2000, `misaligned`=0, `redirect`=1.
- Stall
  - Stimulus: a taken JAL captured, then `stall` held 3 cycles.
  - Response: `redirect` high only in the first of those cycles and all `m_*` values held. On release the first captured instruction has `m_valid`=0; the next one is valid.
- Flush and reset
  - `flush` together with `stall` in a cycle where `m_valid`=1 gives `m_valid`=0 the next cycle.
  - `rst` pulsed mid-cycle gives all outputs 0 without waiting for a clock edge.
- Wrap-around
  - Stimulus: pc=0xFFFFFFFC, imm=8, BNE with `ex_eq`=0.
  - Response: `redirect_pc`=0x00000004 and `m_pc_plus4`=0x00000000.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register for the RV32I core.
// Captures the ALU result and control fields, resolves branches and
// JAL/JALR targets, issues a single-cycle PC redirect for each taken
// transfer, and squashes the one wrong-path instruction that follows.
//
// Handshake: there is no valid/ready pair here. The slot advances on every
// rising edge unless stall is high. flush kills the occupant and overrides
// stall. m_valid marks a real instruction in the MEM slot. redirect is
// asserted for exactly one unstalled-or-stalled cycle per taken transfer.
module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_alu_out,
  input  logic             ex_eq,
  input  logic             ex_c,
  input  logic             ex_s,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ex_imm,
  input  logic [WIDTH-1:0] ex_rs2_data,
  input  logic [REGW-1:0]  ex_rd,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_branch,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic             stall,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_alu_out,
  output logic [WIDTH-1:0] m_rs2_data,
  output logic [WIDTH-1:0] m_pc_plus4,
  output logic [REGW-1:0]  m_rd,
  output logic [2:0]       m_funct3,
  output logic             m_reg_write,
  output logic             m_mem_read,
  output logic             m_mem_write,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             misaligned,
  output logic [1:0]       dbg_state
);

  // Redirect FSM for the occupied MEM slot.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // no taken transfer pending
    S_ISSUE = 2'd1,  // taken transfer, redirect not yet issued
    S_DONE  = 2'd2   // redirect already issued while stalled
  } redir_state_e;

  redir_state_e state_q, state_d;

  logic             cond;
  logic             take;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc_plus4;
  logic             capture_valid;
  logic             issued_q;
  logic             squash_q;
  logic             take_q;
  logic [WIDTH-1:0] target_q;
  logic             reg_write_q;
  logic             mem_read_q;
  logic             mem_write_q;

  // Branch condition decode from funct3 and the ALU compare flags.
  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = ex_eq;
      3'b001:  cond = ~ex_eq;
      3'b100:  cond = ex_s;
      3'b101:  cond = ~ex_s;
      3'b110:  cond = ex_c;
      3'b111:  cond = ~ex_c;
      default: cond = 1'b0;
    endcase
  end

  assign take     = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond));
  // JALR clears bit 0 only; bit 1 survives so misalignment can be flagged.
  assign target   = ex_jalr ? {ex_alu_out[WIDTH-1:1], 1'b0} : (ex_pc + ex_imm);
  assign pc_plus4 = ex_pc + WIDTH'(4);

  assign issued_q      = (state_q == S_DONE);
  assign misaligned    = m_valid & take_q & (target_q[1:0] != 2'b00);
  assign redirect      = m_valid & take_q & ~issued_q & ~misaligned;
  assign redirect_pc   = target_q;
  // The instruction behind a redirect (now, or one issued during a stall) is wrong-path.
  assign capture_valid = ex_valid & ~(redirect | squash_q);

  assign m_reg_write = m_valid & reg_write_q;
  assign m_mem_read  = m_valid & mem_read_q;
  assign m_mem_write = m_valid & mem_write_q;
  assign dbg_state   = state_q;

  // Redirect FSM next-state: flush clears, stall records an issued redirect.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (stall) begin
      if (state_q == S_ISSUE && redirect) state_d = S_DONE;
    end else begin
      state_d = (capture_valid & take) ? S_ISSUE : S_IDLE;
    end
  end

  // Redirect FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Squash flag: remembers a redirect issued while the slot was stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        squash_q <= 1'b0;
    else if (flush) squash_q <= 1'b0;
    else if (stall) squash_q <= squash_q | redirect;
    else            squash_q <= 1'b0;
  end

  // Slot valid bit: flush kills, stall holds, capture may squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         m_valid <= 1'b0;
    else if (flush)  m_valid <= 1'b0;
    else if (!stall) m_valid <= capture_valid;
  end

  // Datapath and control capture; squashed captures still load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_alu_out   <= '0;
      m_rs2_data  <= '0;
      m_pc_plus4  <= '0;
      m_rd        <= '0;
      m_funct3    <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      take_q      <= 1'b0;
      target_q    <= '0;
    end else if (!flush && !stall) begin
      m_alu_out   <= ex_alu_out;
      m_rs2_data  <= ex_rs2_data;
      m_pc_plus4  <= pc_plus4;
      m_rd        <= ex_rd;
      m_funct3    <= ex_funct3;
      reg_write_q <= ex_reg_write;
      mem_read_q  <= ex_mem_read;
      mem_write_q <= ex_mem_write;
      take_q      <= take;
      target_q    <= target;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors for ex_mem_stage. Each vector carries the
// hand-computed outputs expected after its capture edge; a monitor pops and
// compares them one cycle later.
module tb_ex_mem_stage;
  localparam int W = 32;
  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_JAL = 2'd2, K_JALR = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ex_valid, ex_eq, ex_c, ex_s;
  logic [W-1:0] ex_alu_out, ex_pc, ex_imm, ex_rs2_data;
  logic [4:0]   ex_rd;
  logic [2:0]   ex_funct3;
  logic         ex_reg_write, ex_mem_read, ex_mem_write;
  logic         ex_branch, ex_jal, ex_jalr, stall, flush;
  logic         m_valid, m_reg_write, m_mem_read, m_mem_write;
  logic [W-1:0] m_alu_out, m_rs2_data, m_pc_plus4, redirect_pc;
  logic [4:0]   m_rd;
  logic [2:0]   m_funct3;
  logic         redirect, misaligned;
  logic [1:0]   dbg_state;

  typedef struct packed {
    logic [7:0]   id;
    logic         care;   // compare datapath fields as well as controls
    logic         v, rw, mw, redir, mis;
    logic [W-1:0] rpc, pc4, alu;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage #(.WIDTH(W), .REGW(5)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_eq(ex_eq), .ex_c(ex_c), .ex_s(ex_s), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .stall(stall), .flush(flush), .m_valid(m_valid),
    .m_alu_out(m_alu_out), .m_rs2_data(m_rs2_data), .m_pc_plus4(m_pc_plus4),
    .m_rd(m_rd), .m_funct3(m_funct3), .m_reg_write(m_reg_write),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write), .redirect(redirect),
    .redirect_pc(redirect_pc), .misaligned(misaligned), .dbg_state(dbg_state)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] id, input logic care,
                              input logic v, input logic rw, input logic mw,
                              input logic redir, input logic mis,
                              input logic [W-1:0] rpc, input logic [W-1:0] pc4,
                              input logic [W-1:0] alu);
    exp_t e;
    e.id = id; e.care = care; e.v = v; e.rw = rw; e.mw = mw;
    e.redir = redir; e.mis = mis; e.rpc = rpc; e.pc4 = pc4; e.alu = alu;
    return e;
  endfunction

  task automatic set_idle();
    ex_valid = 1'b0; ex_alu_out = '0; ex_eq = 1'b0; ex_c = 1'b0; ex_s = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs2_data = '0; ex_rd = '0; ex_funct3 = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  // Driver: present one EX instruction for the next edge and queue its outcome.
  task automatic drive(input logic v, input logic [1:0] kind, input logic [2:0] f3,
                       input logic eq, input logic c, input logic s,
                       input logic [W-1:0] pc, input logic [W-1:0] imm,
                       input logic [W-1:0] alu, input logic mw,
                       input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    #1;
    ex_valid     = v;
    ex_alu_out   = alu;
    ex_eq        = eq;
    ex_c         = c;
    ex_s         = s;
    ex_pc        = pc;
    ex_imm       = imm;
    ex_rs2_data  = alu ^ 32'h5A5A_0000;
    ex_rd        = pc[6:2];
    ex_funct3    = f3;
    ex_branch    = (kind == K_BR);
    ex_jal       = (kind == K_JAL);
    ex_jalr      = (kind == K_JALR);
    ex_reg_write = ~mw & (kind != K_BR);
    ex_mem_read  = 1'b0;
    ex_mem_write = mw;
    stall        = st;
    flush        = fl;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({m_valid, m_reg_write, m_mem_read, m_mem_write, redirect, misaligned} !== 6'b0 ||
        m_alu_out !== '0 || m_rs2_data !== '0 || m_pc_plus4 !== '0 ||
        redirect_pc !== '0 || m_rd !== '0 || m_funct3 !== '0) begin
      errors++;
      $display("FAIL %s: got ctl=%b alu=%h rs2=%h pc4=%h rpc=%h rd=%h f3=%h, required all zero",
               name, {m_valid, m_reg_write, m_mem_read, m_mem_write, redirect, misaligned},
               m_alu_out, m_rs2_data, m_pc_plus4, redirect_pc, m_rd, m_funct3);
    end
  endtask

  // Scoreboard monitor: compare DUT outputs with the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic ok;
        mon_e = exp_q.pop_front();
        checks++;
        ok = (m_valid === mon_e.v) && (m_reg_write === mon_e.rw) &&
             (m_mem_write === mon_e.mw) && (m_mem_read === 1'b0) &&
             (redirect === mon_e.redir) && (misaligned === mon_e.mis);
        if (mon_e.care)
          ok = ok && (redirect_pc === mon_e.rpc) && (m_pc_plus4 === mon_e.pc4) &&
               (m_alu_out === mon_e.alu);
        if (!ok) begin
          errors++;
          $display("FAIL step%0d: got v=%b rw=%b mr=%b mw=%b redir=%b mis=%b rpc=%h pc4=%h alu=%h; want v=%b rw=%b mr=0 mw=%b redir=%b mis=%b rpc=%h pc4=%h alu=%h (data checked=%b)",
                   mon_e.id, m_valid, m_reg_write, m_mem_read, m_mem_write, redirect,
                   misaligned, redirect_pc, m_pc_plus4, m_alu_out, mon_e.v, mon_e.rw,
                   mon_e.mw, mon_e.redir, mon_e.mis, mon_e.rpc, mon_e.pc4, mon_e.alu,
                   mon_e.care);
        end
      end
    end
  end

  // Stimulus: directed vectors, then async reset, then report.
  initial begin
    set_idle();
    #1 rst = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, wrong-path squashed, target instruction valid
    drive(1, K_BR,   3'b000, 1, 0, 0, 32'h100, 32'h20, 32'h55, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 0, 32'h120, 32'h104, 32'h55));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h104, 32'h0,  32'h11, 0, 0, 0, mk(2, 1, 0, 0, 0, 0, 0, 32'h104, 32'h108, 32'h11));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h120, 32'h0,  32'h22, 0, 0, 0, mk(3, 1, 1, 1, 0, 0, 0, 32'h120, 32'h124, 32'h22));
    // BLTU not taken, then a store captured valid
    drive(1, K_BR,   3'b110, 0, 0, 0, 32'h124, 32'h40, 32'h33, 0, 0, 0, mk(4, 1, 1, 0, 0, 0, 0, 32'h164, 32'h128, 32'h33));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h128, 32'h0,  32'h44, 1, 0, 0, mk(5, 1, 1, 0, 1, 0, 0, 32'h128, 32'h12C, 32'h44));
    // funct3=010 never taken even with every flag set
    drive(1, K_BR,   3'b010, 1, 1, 1, 32'h12C, 32'h40, 32'h0,  0, 0, 0, mk(6, 1, 1, 0, 0, 0, 0, 32'h16C, 32'h130, 32'h0));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h130, 32'h0,  32'h66, 0, 0, 0, mk(7, 1, 1, 1, 0, 0, 0, 32'h130, 32'h134, 32'h66));
    // BLT taken backwards
    drive(1, K_BR,   3'b100, 0, 0, 1, 32'h134, 32'hFFFF_FFF8, 32'h77, 0, 0, 0, mk(8, 1, 1, 0, 0, 1, 0, 32'h12C, 32'h138, 32'h77));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h138, 32'h0,  32'h88, 0, 0, 0, mk(9, 1, 0, 0, 0, 0, 0, 32'h138, 32'h13C, 32'h88));
    // JALR misaligned: flagged, no redirect, no squash
    drive(1, K_JALR, 3'b000, 0, 0, 0, 32'h200, 32'h0,  32'h2003, 0, 0, 0, mk(10, 1, 1, 1, 0, 0, 1, 32'h2002, 32'h204, 32'h2003));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h204, 32'h0,  32'h99, 0, 0, 0, mk(11, 1, 1, 1, 0, 0, 0, 32'h204, 32'h208, 32'h99));
    // JALR aligned after clearing bit 0
    drive(1, K_JALR, 3'b000, 0, 0, 0, 32'h208, 32'h0,  32'h2001, 0, 0, 0, mk(12, 1, 1, 1, 0, 1, 0, 32'h2000, 32'h20C, 32'h2001));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h20C, 32'h0,  32'hAA, 0, 0, 0, mk(13, 1, 0, 0, 0, 0, 0, 32'h20C, 32'h210, 32'hAA));
    // JAL taken then three stalled cycles: redirect once, contents held
    drive(1, K_JAL,  3'b000, 0, 0, 0, 32'h300, 32'h100, 32'hBB, 0, 0, 0, mk(14, 1, 1, 1, 0, 1, 0, 32'h400, 32'h304, 32'hBB));
    for (int i = 0; i < 3; i++)
      drive(1, K_ALU, 3'b000, 0, 0, 0, 32'h304, 32'h0, 32'hCC, 0, 1, 0, mk(8'(15 + i), 1, 1, 1, 0, 0, 0, 32'h400, 32'h304, 32'hBB));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h304, 32'h0,  32'hCC, 0, 0, 0, mk(18, 1, 0, 0, 0, 0, 0, 32'h304, 32'h308, 32'hCC));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h400, 32'h0,  32'hDD, 0, 0, 0, mk(19, 1, 1, 1, 0, 0, 0, 32'h400, 32'h404, 32'hDD));
    // flush together with stall kills a valid slot
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h404, 32'h0,  32'hEE, 0, 1, 1, mk(20, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h404, 32'h0,  32'hEE, 0, 0, 0, mk(21, 1, 1, 1, 0, 0, 0, 32'h404, 32'h408, 32'hEE));
    // flush during a redirect cycle clears the pending squash
    drive(1, K_JAL,  3'b000, 0, 0, 0, 32'h500, 32'h10, 32'h0,  0, 0, 0, mk(22, 1, 1, 1, 0, 1, 0, 32'h510, 32'h504, 32'h0));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h504, 32'h0,  32'h0,  0, 0, 1, mk(23, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h510, 32'h0,  32'h12, 0, 0, 0, mk(24, 1, 1, 1, 0, 0, 0, 32'h510, 32'h514, 32'h12));
    // BNE wrap-around of target and pc+4
    drive(1, K_BR,   3'b001, 0, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h34, 0, 0, 0, mk(25, 1, 1, 0, 0, 1, 0, 32'h4, 32'h0, 32'h34));
    drive(1, K_ALU,  3'b000, 0, 0, 0, 32'h0,   32'h0,  32'h56, 0, 0, 0, mk(26, 1, 0, 0, 0, 0, 0, 32'h0, 32'h4, 32'h56));
    // invalid JAL never takes
    drive(0, K_JAL,  3'b000, 0, 0, 0, 32'h600, 32'h4,  32'h0,  0, 0, 0, mk(27, 1, 0, 0, 0, 0, 0, 32'h604, 32'h604, 32'h0));
    // BGEU taken
    drive(1, K_BR,   3'b111, 0, 0, 0, 32'h700, 32'h20, 32'h0,  0, 0, 0, mk(28, 1, 1, 0, 0, 1, 0, 32'h720, 32'h704, 32'h0));

    // Mid-cycle asynchronous reset while redirect is active
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1 check_zero("async_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    @(negedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
